// File: rtl/reg_file_param.sv
// Parametrised integer register file: two combinational read ports, one write port,
// optional hardwired zero register and write bypass, with a post-reset clear sweep.
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [WIDTH-1:0]  writeData,
  output logic [WIDTH-1:0]  data1,
  output logic [WIDTH-1:0]  data2,
  output logic              ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = {ADDR_W{1'b0}};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Read resolution priority: not ready, hardwired zero, bypass, then the array.
  function automatic logic [WIDTH-1:0] resolve_read(
    input logic              vld,
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  entry,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [WIDTH-1:0]  wr_data
  );
    logic [WIDTH-1:0] result;
    if (!vld) begin
      result = {WIDTH{1'b0}};
    end else if (ZERO_REG && (addr == ZERO_ADDR)) begin
      result = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en && (wr_addr == addr)) begin
      result = wr_data;
    end else begin
      result = entry;
    end
    return result;
  endfunction

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    we         = 1'b0;
    waddr      = ptr;
    wdata      = {WIDTH{1'b0}};
    if (reset) begin
      we = 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          we       = 1'b1;
          ptr_next = ptr + ADDR_W'(1);
          if (ptr == LAST_ENTRY) begin
            state_next = IDLE;
          end else begin
            state_next = CLEAR;
          end
        end
        IDLE: begin
          if (regWrite && !(ZERO_REG && (writeReg == ZERO_ADDR))) begin
            we    = 1'b1;
            waddr = writeReg;
            wdata = writeData;
          end else begin
            we = 1'b0;
          end
        end
        default: begin
          state_next = CLEAR;
          ptr_next   = ZERO_ADDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= ZERO_ADDR;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      ready <= (state_next == IDLE);
    end
  end

  // The array has no reset of its own; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign data1 = resolve_read(ready, read1, mem[read1], regWrite, writeReg, writeData);
  assign data2 = resolve_read(ready, read2, mem[read2], regWrite, writeReg, writeData);

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised integer register file for the RISC-V datapath: two asynchronous read ports, one synchronous write port, an optional hardwired-zero register 0, and optional write-to-read bypass. After reset, a sequential clear sweep zeroes every entry, one per cycle, and drops `ready` until the sweep completes. It sits between decode (read addresses) and writeback (write port) and replaces the unparametrised, unreset 32x32 register file.

## Interface
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: number of registers, ≥2, power of two.
- `ADDR_W`, 5: address width, must equal log2(DEPTH).
- `ZERO_REG`, 1: 1 means register 0 reads as 0 and writes to it are discarded.
- `BYPASS`, 1: 1 means a same-cycle write is forwarded to a matching read port.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `regWrite` input 1: write enable.
- `read1` input ADDR_W: read port 1 address.
- `read2` input ADDR_W: read port 2 address.
- `writeReg` input ADDR_W: write address.
- `writeData` input WIDTH: write data.
- `data1` output WIDTH: read port 1 data (combinational).
- `data2` output WIDTH: read port 2 data (combinational).
- `ready` output 1: high when the file is initialised and accepting writes.

## Operation
- The FSM has two states: CLEAR and IDLE. A sweep pointer `ptr` is ADDR_W bits wide.
- While `reset` is high, the rising edge forces the state to CLEAR and `ptr` to 0. No array write occurs on a reset edge.
- In CLEAR with `reset` low, each edge writes 0 to entry `ptr` and increments `ptr`.
  - When the edge clears entry DEPTH-1, the state becomes IDLE and `ptr` wraps to 0.
- `ready` is 1 only in IDLE and is registered with the state.
- In IDLE, on an edge with `regWrite`=1, the array stores `writeData` at `writeReg`.
  - If `ZERO_REG`=1 and `writeReg`=0, the write is discarded.
- While `ready`=0, `regWrite` is ignored. Writes are never queued for later.
- Read N (N = 1, 2) is resolved by the first matching rule:
  1. If `ready`=0, `dataN` = 0.
  2. If `ZERO_REG`=1 and `readN`=0, `dataN` = 0.
  3. If `BYPASS`=1, `regWrite`=1, and `writeReg`=`readN`, `dataN` = `writeData`.
  4. Otherwise, `dataN` = the array entry at `readN`.
- Both read ports are independent. The same address on both ports returns identical data.
- Array contents are undefined before the first sweep completes. The read-masking rule hides this.

## Timing
- Reset values: `ready`=0 and `data1`=`data2`=0 from the first edge with `reset` high.
- Sweep length: with `reset` deasserted before edge E, `ready` rises after edge E+DEPTH-1. That is, `ready` is 1 in the cycle following DEPTH clearing edges.
- Reset asserted mid-sweep or in IDLE: the sweep restarts from `ptr`=0 and `ready` falls after that edge.
- Write latency: data written at edge T is visible at the array output from T onward (zero cycles after the edge).
  - With `BYPASS`=1, it is also visible combinationally in the cycle before edge T.
- Reads have zero latency. There are no read enables, stalls, or handshakes. Downstream must not issue instructions until `ready`=1.
- A write and a read of the same address in the same cycle with `BYPASS`=0 returns the old value.
- A write in the same cycle as `reset` is dropped.

## Test plan
- Reset sweep:
  - Stimulus: hold `reset` for 2 cycles, release, and count edges.
  - Required: `ready`=0 for exactly 32 edges after release, then 1.
  - Required: reads of entries 0, 1, 17, and 31 all return 0x00000000.
- Write/read:
  - Stimulus: write 0xDEADBEEF to register 5 and 0x12345678 to register 31. Then read 5 on port 1 and 31 on port 2.
  - Required: `data1`=0xDEADBEEF and `data2`=0x12345678.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to register 0, then read 0 on both ports.
  - Required: both ports read 0.
  - Stimulus: repeat with `ZERO_REG`=0.
  - Required: both ports read 0xFFFFFFFF.
- Bypass:
  - Setup: register 7 holds 0xAAAA0000.
  - Stimulus: in the same cycle, drive `regWrite`=1, `writeReg`=7, `writeData`=0x0000BBBB, and `read1`=`read2`=7.
  - Required: both ports read 0x0000BBBB before the edge. With `BYPASS`=0, both ports read 0xAAAA0000 before the edge.
- Writes during sweep:
  - Stimulus: assert `regWrite` to register 3 with 0x55 during CLEAR.
  - Required: after `ready`=1, register 3 reads 0.
- Reset mid-operation:
  - Stimulus: fill registers 1–31 with nonzero values. Pulse `reset` for 1 cycle halfway through a second sweep.
  - Required: `ready` stays 0 for 32 edges after release, and all entries read 0 afterwards.
  - Stimulus: repeat with `WIDTH`=64 and `DEPTH`=16.
  - Required: `ready`=0 for 16 edges after release.
